// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-clock controller.
package alarm_pkg;

  localparam logic [1:0] FIELD_SEC  = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_HOUR = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } fsm_t;

  localparam logic [3:0] LSB_MAX      = 4'd9;
  localparam logic [3:0] SEC_MSB_MAX  = 4'd5;
  localparam logic [3:0] HOUR_MSB_MAX = 4'd2;
  localparam logic [3:0] HOUR_LSB_MAX = 4'd3;

  typedef struct packed {
    logic [3:0] msb;
    logic [3:0] lsb;
  } bcd2_t;

endpackage

// File: rtl/alarm_ctrl_bcd2_inc.sv
// Combinational two-digit BCD incrementer; wraps to 00 after MAX_MSB:MAX_LSB.
module bcd2_inc
  import alarm_pkg::*;
#(
  parameter logic [3:0] MAX_MSB = SEC_MSB_MAX,
  parameter logic [3:0] MAX_LSB = LSB_MAX
) (
  input  bcd2_t val,
  output bcd2_t nxt
);

  always_comb begin
    nxt = val;
    if (val.msb >= MAX_MSB && val.lsb >= MAX_LSB) begin
      nxt = '0;
    end else if (val.lsb >= LSB_MAX) begin
      nxt.lsb = '0;
      nxt.msb = val.msb + 4'd1;
    end else begin
      nxt.lsb = val.lsb + 4'd1;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm-clock UI controller: field edit, set-time pulses, match detect, ring/snooze.
// Snooze support is built only when ALARM_CTRL_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 30,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       btn_next_tick,
  input  logic       btn_inc_tick,
  input  logic       btn_on_tick,
  input  logic       btn_set_tick,
  input  logic [3:0] cur_secMSB,
  input  logic [3:0] cur_secLSB,
  input  logic [3:0] cur_minMSB,
  input  logic [3:0] cur_minLSB,
  input  logic [3:0] cur_hourMSB,
  input  logic [3:0] cur_hourLSB,
  output logic [1:0] state,
  output logic       settime,
  output logic       on,
  output logic [3:0] alarmsecMSB,
  output logic [3:0] alarmsecLSB,
  output logic [3:0] alarmminMSB,
  output logic [3:0] alarmminLSB,
  output logic [3:0] alarmhourMSB,
  output logic [3:0] alarmhourLSB,
  output logic       time_inc_sec,
  output logic       time_inc_min,
  output logic       time_inc_hour,
  output logic       ring
);

  localparam int unsigned CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic             settime_q, settime_d, on_q, on_d, ring_q, ring_d;
  logic             match_q, match_d, match_rise, dismiss;
  logic             time_inc_sec_q, time_inc_sec_d;
  logic             time_inc_min_q, time_inc_min_d;
  logic             time_inc_hour_q, time_inc_hour_d;
  bcd2_t            alarm_sec_q, alarm_sec_d, alarm_min_q, alarm_min_d;
  bcd2_t            alarm_hour_q, alarm_hour_d;
  bcd2_t            sec_inc, min_inc, hour_inc;

  bcd2_inc #(.MAX_MSB(SEC_MSB_MAX), .MAX_LSB(LSB_MAX)) u_sec_inc (
    .val(alarm_sec_q), .nxt(sec_inc));
  bcd2_inc #(.MAX_MSB(SEC_MSB_MAX), .MAX_LSB(LSB_MAX)) u_min_inc (
    .val(alarm_min_q), .nxt(min_inc));
  bcd2_inc #(.MAX_MSB(HOUR_MSB_MAX), .MAX_LSB(HOUR_LSB_MAX)) u_hour_inc (
    .val(alarm_hour_q), .nxt(hour_inc));

  assign match_d = on_q & ~settime_q &
                   ({cur_hourMSB, cur_hourLSB, cur_minMSB, cur_minLSB, cur_secMSB, cur_secLSB}
                    == {alarm_hour_q, alarm_min_q, alarm_sec_q});
  // Only a fresh match rings, so holding at equality after a dismiss stays quiet.
  assign match_rise = match_d & ~match_q;

`ifdef ALARM_CTRL_SNOOZE_EN
  assign dismiss = btn_next_tick | btn_set_tick | btn_on_tick;
`else
  assign dismiss = btn_next_tick | btn_set_tick | btn_on_tick | btn_inc_tick;
`endif

  always_comb begin
    state_d         = state_q;
    settime_d       = settime_q ^ btn_set_tick;
    on_d            = on_q ^ btn_on_tick;
    alarm_sec_d     = alarm_sec_q;
    alarm_min_d     = alarm_min_q;
    alarm_hour_d    = alarm_hour_q;
    time_inc_sec_d  = 1'b0;
    time_inc_min_d  = 1'b0;
    time_inc_hour_d = 1'b0;
    fsm_d           = fsm_q;
    cnt_d           = cnt_q;

    if (btn_next_tick) begin
      state_d = (state_q >= FIELD_HOUR) ? FIELD_SEC : state_q + 2'd1;
    end

    if (btn_inc_tick && fsm_q != RING) begin
      case (state_q)
        FIELD_SEC:  if (settime_q) time_inc_sec_d  = 1'b1; else alarm_sec_d  = sec_inc;
        FIELD_MIN:  if (settime_q) time_inc_min_d  = 1'b1; else alarm_min_d  = min_inc;
        FIELD_HOUR: if (settime_q) time_inc_hour_d = 1'b1; else alarm_hour_d = hour_inc;
        default: ;
      endcase
    end

    case (fsm_q)
      IDLE: begin
        if (match_rise) begin
          fsm_d = RING;
          cnt_d = '0;
        end
      end
      RING: begin
        if (dismiss) begin
          fsm_d = IDLE;
`ifdef ALARM_CTRL_SNOOZE_EN
        end else if (btn_inc_tick) begin
          fsm_d = SNOOZE;
          cnt_d = '0;
`endif
        end else if (cnt_q == CNT_W'(RING_SECS)) begin
          fsm_d = IDLE;
        end else if (sec_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef ALARM_CTRL_SNOOZE_EN
      SNOOZE: begin
        if (btn_on_tick) begin
          on_d  = 1'b0;
          fsm_d = IDLE;
        end else if (cnt_q == CNT_W'(SNOOZE_SECS)) begin
          fsm_d = RING;
          cnt_d = '0;
        end else if (sec_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: fsm_d = IDLE;
    endcase

    ring_d = (fsm_d == RING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q           <= IDLE;
      cnt_q           <= '0;
      state_q         <= FIELD_SEC;
      settime_q       <= 1'b0;
      on_q            <= 1'b0;
      ring_q          <= 1'b0;
      match_q         <= 1'b0;
      time_inc_sec_q  <= 1'b0;
      time_inc_min_q  <= 1'b0;
      time_inc_hour_q <= 1'b0;
      alarm_sec_q     <= '0;
      alarm_min_q     <= '0;
      alarm_hour_q    <= '0;
    end else begin
      fsm_q           <= fsm_d;
      cnt_q           <= cnt_d;
      state_q         <= state_d;
      settime_q       <= settime_d;
      on_q            <= on_d;
      ring_q          <= ring_d;
      match_q         <= match_d;
      time_inc_sec_q  <= time_inc_sec_d;
      time_inc_min_q  <= time_inc_min_d;
      time_inc_hour_q <= time_inc_hour_d;
      alarm_sec_q     <= alarm_sec_d;
      alarm_min_q     <= alarm_min_d;
      alarm_hour_q    <= alarm_hour_d;
    end
  end

  assign state         = state_q;
  assign settime       = settime_q;
  assign on            = on_q;
  assign ring          = ring_q;
  assign time_inc_sec  = time_inc_sec_q;
  assign time_inc_min  = time_inc_min_q;
  assign time_inc_hour = time_inc_hour_q;
  assign alarmsecMSB   = alarm_sec_q.msb;
  assign alarmsecLSB   = alarm_sec_q.lsb;
  assign alarmminMSB   = alarm_min_q.msb;
  assign alarmminLSB   = alarm_min_q.lsb;
  assign alarmhourMSB  = alarm_hour_q.msb;
  assign alarmhourLSB  = alarm_hour_q.lsb;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios then random stimulus vs a reference model.
module tb_alarm_ctrl;

  localparam int unsigned RING_SECS   = 30;
  localparam int unsigned SNOOZE_SECS = 300;
`ifdef ALARM_CTRL_SNOOZE_EN
  localparam bit SNOOZE_BUILT = 1'b1;
`else
  localparam bit SNOOZE_BUILT = 1'b0;
`endif

  localparam logic [4:0] B_NEXT = 5'b10000;
  localparam logic [4:0] B_INC  = 5'b01000;
  localparam logic [4:0] B_ON   = 5'b00100;
  localparam logic [4:0] B_SET  = 5'b00010;
  localparam logic [4:0] B_SEC  = 5'b00001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sec_tick = 1'b0, btn_next_tick = 1'b0, btn_inc_tick = 1'b0;
  logic btn_on_tick = 1'b0, btn_set_tick = 1'b0;
  int   cur_h = 0, cur_m = 0, cur_s = 0;
  logic [3:0] cur_secMSB, cur_secLSB, cur_minMSB, cur_minLSB, cur_hourMSB, cur_hourLSB;
  logic [1:0] state;
  logic settime, on, ring, time_inc_sec, time_inc_min, time_inc_hour;
  logic [3:0] alarmsecMSB, alarmsecLSB, alarmminMSB, alarmminLSB, alarmhourMSB, alarmhourLSB;

  assign cur_secMSB  = 4'(cur_s / 10);
  assign cur_secLSB  = 4'(cur_s % 10);
  assign cur_minMSB  = 4'(cur_m / 10);
  assign cur_minLSB  = 4'(cur_m % 10);
  assign cur_hourMSB = 4'(cur_h / 10);
  assign cur_hourLSB = 4'(cur_h % 10);

  alarm_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .btn_next_tick(btn_next_tick), .btn_inc_tick(btn_inc_tick),
    .btn_on_tick(btn_on_tick), .btn_set_tick(btn_set_tick),
    .cur_secMSB(cur_secMSB), .cur_secLSB(cur_secLSB),
    .cur_minMSB(cur_minMSB), .cur_minLSB(cur_minLSB),
    .cur_hourMSB(cur_hourMSB), .cur_hourLSB(cur_hourLSB),
    .state(state), .settime(settime), .on(on),
    .alarmsecMSB(alarmsecMSB), .alarmsecLSB(alarmsecLSB),
    .alarmminMSB(alarmminMSB), .alarmminLSB(alarmminLSB),
    .alarmhourMSB(alarmhourMSB), .alarmhourLSB(alarmhourLSB),
    .time_inc_sec(time_inc_sec), .time_inc_min(time_inc_min),
    .time_inc_hour(time_inc_hour), .ring(ring));

  always #5 clk = ~clk;

  // Reference model: alarm kept as plain integer hours/minutes/seconds.
  int       m_field, a_h, a_m, a_s, m_secs;
  bit       m_set, m_on, m_ringing, m_snoozing, m_prev_match;
  bit [2:0] m_pulse;
  int       checks = 0, errors = 0;

  task automatic model_reset();
    m_field = 0; a_h = 0; a_m = 0; a_s = 0; m_secs = 0;
    m_set = 0; m_on = 0; m_ringing = 0; m_snoozing = 0; m_prev_match = 0;
    m_pulse = '0;
  endtask

  task automatic model_step();
    bit match, fresh, stop;
    if (reset) begin
      model_reset();
      return;
    end
    match = m_on && !m_set && cur_h == a_h && cur_m == a_m && cur_s == a_s;
    fresh = match && !m_prev_match;
    m_prev_match = match;
    m_pulse = '0;
    if (btn_inc_tick && !m_ringing) begin
      if (m_set) m_pulse[m_field] = 1'b1;
      else if (m_field == 0) a_s = (a_s + 1) % 60;
      else if (m_field == 1) a_m = (a_m + 1) % 60;
      else a_h = (a_h + 1) % 24;
    end
    if (btn_next_tick) m_field = (m_field + 1) % 3;
    if (btn_set_tick) m_set = !m_set;
    if (btn_on_tick) m_on = !m_on;
    if (m_ringing) begin
      stop = btn_next_tick || btn_set_tick || btn_on_tick || (btn_inc_tick && !SNOOZE_BUILT);
      if (stop) m_ringing = 0;
      else if (btn_inc_tick) begin m_ringing = 0; m_snoozing = 1; m_secs = 0; end
      else if (m_secs == RING_SECS) m_ringing = 0;
      else if (sec_tick) m_secs++;
    end else if (m_snoozing) begin
      if (btn_on_tick) begin m_on = 0; m_snoozing = 0; end
      else if (m_secs == SNOOZE_SECS) begin m_snoozing = 0; m_ringing = 1; m_secs = 0; end
      else if (sec_tick) m_secs++;
    end else if (fresh) begin
      m_ringing = 1;
      m_secs = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [23:0] exp_alarm;
    exp_alarm = {4'(a_h / 10), 4'(a_h % 10), 4'(a_m / 10), 4'(a_m % 10), 4'(a_s / 10), 4'(a_s % 10)};
    check("state", 32'(state), m_field);
    check("settime", 32'(settime), 32'(m_set));
    check("on", 32'(on), 32'(m_on));
    check("alarm", 32'({alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB}),
          32'(exp_alarm));
    check("time_inc", 32'({time_inc_hour, time_inc_min, time_inc_sec}), 32'(m_pulse));
    check("ring", 32'(ring), 32'(m_ringing));
  endtask

  task automatic cyc(input logic [4:0] b);
    {btn_next_tick, btn_inc_tick, btn_on_tick, btn_set_tick, sec_tick} = b;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    {btn_next_tick, btn_inc_tick, btn_on_tick, btn_set_tick, sec_tick} = '0;
  endtask

  task automatic cycn(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(b);
  endtask

  task automatic sec_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(B_SEC);
      cyc('0);
    end
  endtask

  initial begin
    logic [4:0] b;
    model_reset();
    reset = 1'b1;
    cycn('0, 2);
    check("reset_ring", 32'(ring), 0);
    check("reset_alarm", 32'({alarmhourMSB, alarmsecLSB}), 0);
    reset = 1'b0;

    // Alarm hour editing with BCD carry and 23->00 wrap
    cycn(B_NEXT, 2);
    check("field_hour", 32'(state), 2);
    cycn(B_INC, 20);
    check("hour20", 32'({alarmhourMSB, alarmhourLSB}), 32'h20);
    cycn(B_INC, 4);
    check("hour_wrap", 32'({alarmhourMSB, alarmhourLSB}), 0);

    // Seconds to 59, then wrap with minutes untouched
    cyc(B_NEXT);
    cycn(B_INC, 59);
    check("sec59", 32'({alarmsecMSB, alarmsecLSB}), 32'h59);
    cyc(B_INC);
    check("sec_wrap", 32'({alarmsecMSB, alarmsecLSB}), 0);
    check("min_kept", 32'({alarmminMSB, alarmminLSB}), 0);

    // Set-time increment pulse on the minute line
    cyc(B_SET);
    check("settime_on", 32'(settime), 1);
    cyc(B_NEXT);
    cyc(B_INC);
    check("inc_min_pulse", 32'({time_inc_hour, time_inc_min, time_inc_sec}), 32'b010);
    cyc('0);
    check("inc_min_clear", 32'({time_inc_hour, time_inc_min, time_inc_sec}), 0);
    cyc(B_SET);

    // Alarm 00:00:05, ring and auto-timeout
    cycn(B_NEXT, 2);
    cycn(B_INC, 5);
    cyc(B_ON);
    cur_s = 5;
    cyc('0);
    check("ring_start", 32'(ring), 1);
    sec_ticks(RING_SECS - 1);
    check("ring_held", 32'(ring), 1);
    sec_ticks(1);
    cyc('0);
    check("ring_timeout", 32'(ring), 0);
    cycn('0, 10);
    check("no_rering", 32'(ring), 0);

    // Dismiss by next and by on toggle
    cur_s = 0; cyc('0);
    cur_s = 5; cyc('0);
    check("ring_again", 32'(ring), 1);
    cyc(B_NEXT);
    check("dismiss_next", 32'(ring), 0);
    check("dismiss_state", 32'(state), 1);
    cur_s = 0; cyc('0);
    cur_s = 5; cyc('0);
    cyc(B_ON);
    check("dismiss_on_ring", 32'(ring), 0);
    check("dismiss_on_off", 32'(on), 0);

    // Snooze request, then wait out the snooze period
    cyc(B_ON);
    cyc('0);
    check("ring_pre_snooze", 32'(ring), 1);
    cyc(B_INC);
    check("snooze_quiet", 32'(ring), 0);
    sec_ticks(SNOOZE_SECS);
    cyc('0);
    check("snooze_rering", 32'(ring), 32'(SNOOZE_BUILT));
    cyc(B_NEXT);

    // Reset in the middle of a ring
    cur_s = 0; cyc('0);
    cur_s = 5; cyc('0);
    check("ring_pre_reset", 32'(ring), 1);
    reset = 1'b1;
    cyc('0);
    check("reset_mid_ring", 32'({ring, on, settime}), 0);
    reset = 1'b0;

    // Random stimulus against the model
    for (int n = 0; n < 6000; n++) begin
      b = '0;
      if ($urandom_range(15) == 0) b |= B_NEXT;
      if ($urandom_range(5) == 0)  b |= B_INC;
      if ($urandom_range(59) == 0) b |= B_ON;
      if ($urandom_range(59) == 0) b |= B_SET;
      if ($urandom_range(2) == 0)  b |= B_SEC;
      case ($urandom_range(7))
        0, 1, 2, 3: begin cur_h = a_h; cur_m = a_m; cur_s = a_s; end
        4: begin cur_h = $urandom_range(23); cur_m = $urandom_range(59); cur_s = $urandom_range(59); end
        default: ;
      endcase
      reset = ($urandom_range(999) == 0);
      cyc(b);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Sequential controller for the alarm-clock user interface.
- Turns single-cycle button ticks into the display-side control fields (state, settime, on) and holds the alarm time registers as BCD digits.
- Detects alarm match against current time, then drives ring and snooze sequencing.
- Sits between the debounce/edge-detect stage and vga_out; also drives increment pulses to the time-keeping counter during set-time.

Parameters:
- RING_SECS, 30, sec_tick pulses a ring lasts before auto-dismiss (range 1..511).
- SNOOZE_SECS, 300, sec_tick pulses of snooze before re-ring (used only with SNOOZE_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sec_tick  in  1  one-cycle pulse, 1 Hz.
- btn_next_tick  in  1  one-cycle pulse; advance edit field.
- btn_inc_tick  in  1  one-cycle pulse; increment selected field.
- btn_on_tick  in  1  one-cycle pulse; toggle alarm enable.
- btn_set_tick  in  1  one-cycle pulse; toggle set-time mode.
- cur_secMSB, cur_secLSB, cur_minMSB, cur_minLSB, cur_hourMSB, cur_hourLSB  in  4 each  current time, BCD.
- state  out  2  edit field: 0 = sec, 1 = min, 2 = hour.
- settime  out  1  set-time mode active.
- on  out  1  alarm enabled.
- alarmsecMSB, alarmsecLSB, alarmminMSB, alarmminLSB, alarmhourMSB, alarmhourLSB  out  4 each  alarm time, BCD.
- time_inc_sec, time_inc_min, time_inc_hour  out  1 each  one-cycle increment pulses to the time counter.
- ring  out  1  buzzer drive.

Behaviour:
- Clocking: all outputs registered, updated on posedge clk.
- Reset (synchronous): state=0, settime=0, on=0, all alarm digits=0 (00:00:00), time_inc_*=0, ring=0, FSM=IDLE, counters=0, match history=0.
- FSM states: IDLE, RING, SNOOZE.
- Field select (IDLE and SNOOZE): btn_next_tick steps state 0→1→2→0. state=3 is unreachable; if ever seen, the next btn_next_tick forces 0.
- Increment in IDLE, settime=0: btn_inc_tick increments the selected alarm field in BCD.
  - sec/min: 59→00.
  - hour: 23→00; LSB 9→0 carries into MSB (e.g. 19→20).
  - Fields other than the selected one are unaffected.
- Increment in IDLE, settime=1: btn_inc_tick pulses exactly one time_inc_* (chosen by state) for one cycle, one cycle after the tick. Alarm digits are unchanged.
- Same-cycle inc and next: inc acts on the old field, then state advances.
- Toggles: btn_set_tick toggles settime; btn_on_tick toggles on. Both act in any FSM state.
- Match detection:
  - match = on & ~settime & (all six current digits == alarm digits).
  - IDLE→RING on the rising edge of match only (match registered one cycle). Staying at equality after a dismiss does not re-ring.
  - ring goes to 1 on the cycle after the edge is detected.
- RING:
  - Ring counter clears on entry and counts sec_tick pulses.
  - Counter == RING_SECS → IDLE, ring=0.
  - btn_next_tick, btn_set_tick or btn_on_tick dismiss → IDLE; the button's normal action also applies.
  - btn_inc_tick: see Optional Feature. Alarm digits are never modified in RING.
  - on becoming 0 (toggle) → IDLE immediately.
- Simultaneous match edge and any button tick in IDLE: the button action applies and RING is still entered.
- Reset mid-ring or mid-snooze: returns everything to reset values next cycle.

Optional Feature:
- Macro: ALARM_CTRL_SNOOZE_EN.
- Defined:
  - btn_inc_tick in RING → SNOOZE, ring=0; counter clears and counts sec_tick.
  - Counter == SNOOZE_SECS → RING with the ring counter cleared.
  - btn_on_tick during SNOOZE clears on and → IDLE.
  - Edits are allowed during SNOOZE.
- Undefined: btn_inc_tick in RING dismisses to IDLE like the other buttons. SNOOZE state and its counter are not built.

Decomposition:
- Package alarm_pkg:
  - Field codes FIELD_SEC=0, FIELD_MIN=1, FIELD_HOUR=2.
  - FSM encoding IDLE/RING/SNOOZE.
  - BCD limit constants: MSB max 5/2; hour LSB max 3 when MSB=2.
- Sub-module bcd2_inc: combinational two-digit BCD incrementer with wrap, configured for 59 or 23. Instanced three times.

Test Plan:
- Reset, then set alarm: reset; next,next (state=2); inc ×20 → alarm hour 20, state=2. inc ×4 more → hour 00.
- Sec wrap and carry: state=0, inc ×59 → secMSB/LSB=5/9; inc → 0/0; minutes unchanged.
- Set-time pulses: btn_set_tick → settime=1; state=1, inc → time_inc_min high exactly 1 cycle; alarm digits unchanged.
- Ring and timeout: alarm 00:00:05, on=1, feed current time to 00:00:05 → ring=1 next cycle. After 30 sec_ticks ring=0. Holding time at 00:00:05 gives no re-ring.
- Dismiss: during ring, btn_next_tick → ring=0 next cycle and state advances. Same setup with on toggled → ring=0, on=0.
- Snooze (macro defined): during ring, btn_inc_tick → ring=0; after 300 sec_ticks ring=1. Macro undefined: same stimulus → ring stays 0.
